// File: rtl/smpl_vhdl.sv
// smpl_vhdl: 8-bit accumulator CPU, Harvard style, 32-byte instruction and data spaces, external memories.
// Optional internal push/pop stack built only when SMPL_STACK_EN is defined; otherwise push/pop are nops.
module smpl_vhdl #(
    parameter int STACK_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    output logic       rd_mem,
    output logic       wr_mem,
    output logic [4:0] im_abus,
    input  logic [7:0] im_dbus,
    output logic [4:0] dm_abus,
    input  logic [7:0] dm_in_dbus,
    output logic [7:0] dm_out_dbus
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_IMM   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [4:0]  r_pc;
    logic [7:0]  r_ir;
    logic [7:0]  r_acc;
    logic        r_z;
    logic        r_n;

    logic [4:0]  w_pc_nxt;
    logic [7:0]  w_ir_nxt;
    logic [7:0]  w_acc_nxt;
    logic        w_flag_upd;
    logic        w_rd;
    logic        w_wr;

`ifdef SMPL_STACK_EN
    localparam int SPW  = $clog2(STACK_DEPTH) + 1;
    localparam int IDXW = $clog2(STACK_DEPTH);

    logic [7:0]      r_stack [STACK_DEPTH];
    logic [SPW-1:0]  r_sp;
    logic            w_push;
    logic            w_pop;
    logic            w_can_push;
    logic            w_can_pop;
    logic [IDXW-1:0] w_top_idx;

    // SP counts entries, so it needs one bit more than the index to express "full".
    assign w_can_push = (r_sp != SPW'(STACK_DEPTH));
    assign w_can_pop  = (r_sp != '0);
    assign w_top_idx  = r_sp[IDXW-1:0] - IDXW'(1);
`endif

    always_comb begin
        w_next_state = r_state;
        w_pc_nxt     = r_pc;
        w_ir_nxt     = r_ir;
        w_acc_nxt    = r_acc;
        w_flag_upd   = 1'b0;
        w_rd         = 1'b0;
        w_wr         = 1'b0;
`ifdef SMPL_STACK_EN
        w_push       = 1'b0;
        w_pop        = 1'b0;
`endif
        case (r_state)
            S_FETCH: begin
                w_ir_nxt     = im_dbus;
                w_pc_nxt     = r_pc + 5'd1;
                w_next_state = S_EXEC;
            end
            S_EXEC: begin
                w_next_state = S_FETCH;
                case (r_ir[7:5])
                    3'b001: begin
                        w_rd       = 1'b1;
                        w_acc_nxt  = dm_in_dbus;
                        w_flag_upd = 1'b1;
                    end
                    3'b010: begin
                        w_rd       = 1'b1;
                        w_acc_nxt  = r_acc + dm_in_dbus;
                        w_flag_upd = 1'b1;
                    end
                    3'b011: begin
                        w_rd       = 1'b1;
                        w_acc_nxt  = r_acc - dm_in_dbus;
                        w_flag_upd = 1'b1;
                    end
                    3'b100: w_wr = 1'b1;
                    3'b101: w_pc_nxt = r_ir[4:0];
                    3'b110: if (r_z) w_pc_nxt = r_ir[4:0];
                    3'b111: if (r_n) w_pc_nxt = r_ir[4:0];
                    default: begin
                        case (r_ir[4:0])
                            5'h01: begin
`ifdef SMPL_STACK_EN
                                w_push = w_can_push;
`endif
                            end
                            5'h02: begin
`ifdef SMPL_STACK_EN
                                // An empty pop is a pure nop: ACC, flags and SP all hold.
                                if (w_can_pop) begin
                                    w_pop      = 1'b1;
                                    w_acc_nxt  = r_stack[w_top_idx];
                                    w_flag_upd = 1'b1;
                                end
`endif
                            end
                            5'h03:   w_next_state = S_IMM;
                            5'h1F:   w_next_state = S_HALT;
                            default: w_next_state = S_FETCH;
                        endcase
                    end
                endcase
            end
            S_IMM: begin
                w_acc_nxt    = im_dbus;
                w_flag_upd   = 1'b1;
                w_pc_nxt     = r_pc + 5'd1;
                w_next_state = S_FETCH;
            end
            S_HALT:  w_next_state = S_HALT;
            default: w_next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_ir    <= '0;
            r_acc   <= '0;
            r_z     <= 1'b0;
            r_n     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
            r_acc   <= w_acc_nxt;
            if (w_flag_upd) begin
                r_z <= (w_acc_nxt == 8'h00);
                r_n <= w_acc_nxt[7];
            end
        end
    end

`ifdef SMPL_STACK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sp <= '0;
        end else if (w_push) begin
            r_sp <= r_sp + SPW'(1);
        end else if (w_pop) begin
            r_sp <= r_sp - SPW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_stack[r_sp[IDXW-1:0]] <= r_acc;
        end
    end
`endif

    // Outputs are forced low while reset is held, even before the first reset edge.
    assign rd_mem      = w_rd & ~reset;
    assign wr_mem      = w_wr & ~reset;
    assign im_abus     = reset ? 5'd0 : r_pc;
    assign dm_abus     = reset ? 5'd0 : r_ir[4:0];
    assign dm_out_dbus = reset ? 8'd0 : r_acc;

endmodule

// File: tb/tb_smpl_vhdl.sv
// Bench for smpl_vhdl: behavioural instruction/data memories, scoreboard of expected data-memory writes.
module tb_smpl_vhdl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rd_mem;
    logic       wr_mem;
    logic [4:0] im_abus;
    logic [7:0] im_dbus;
    logic [4:0] dm_abus;
    logic [7:0] dm_in_dbus;
    logic [7:0] dm_out_dbus;

    logic [7:0]  imem [32];
    logic [7:0]  dmem [32];
    logic        mem_clr = 1'b0;
    bit          sb_en = 1'b0;
    logic [12:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    smpl_vhdl #(.STACK_DEPTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_mem      (rd_mem),
        .wr_mem      (wr_mem),
        .im_abus     (im_abus),
        .im_dbus     (im_dbus),
        .dm_abus     (dm_abus),
        .dm_in_dbus  (dm_in_dbus),
        .dm_out_dbus (dm_out_dbus)
    );

    always #5 clk = ~clk;

    assign im_dbus    = imem[im_abus];
    assign dm_in_dbus = dmem[dm_abus];

    always @(negedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) dmem[i] <= 8'h00;
        end else if (wr_mem) begin
            dmem[dm_abus] <= dm_out_dbus;
        end
    end

    // Scoreboard: every data-memory write must match the next expected (addr, data) pair.
    always @(negedge clk) begin
        logic [12:0] e;
        if (sb_en && wr_mem) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_write unexpected write addr=%0d data=%h", dm_abus, dm_out_dbus);
            end else begin
                e = exp_q.pop_front();
                if ({dm_abus, dm_out_dbus} !== e) begin
                    errors++;
                    $display("FAIL sb_write got addr=%0d data=%h expected addr=%0d data=%h",
                             dm_abus, dm_out_dbus, e[12:8], e[7:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem;
        for (int i = 0; i < 32; i++) imem[i] = 8'h00;
        mem_clr = 1'b1;
        @(negedge clk);
        #1;
        mem_clr = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic exp_wr(input logic [4:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic wait_halt(input int budget, output bit ok);
        logic [4:0] prev;
        int stable;
        ok = 1'b0;
        stable = 0;
        prev = im_abus;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (im_abus == prev) stable++;
            else stable = 0;
            prev = im_abus;
            if (stable >= 4) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        clear_mem();
        imem[0] = 8'h03;
        imem[1] = 8'hAA;
        reset = 1'b1;
        tick();
        checks++;
        if ({rd_mem, wr_mem, im_abus, dm_abus, dm_out_dbus} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs got rd=%b wr=%b im=%0d dm=%0d out=%h expected all 0",
                     rd_mem, wr_mem, im_abus, dm_abus, dm_out_dbus);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (im_abus !== 5'd1 || dm_abus !== 5'd3) begin
            errors++;
            $display("FAIL reset_first_fetch got im=%0d dm=%0d expected im=1 dm=3", im_abus, dm_abus);
        end
    endtask

    task automatic test_reset_mid_imm;
        clear_mem();
        imem[0] = 8'h03; imem[1] = 8'h33;
        imem[2] = 8'h03; imem[3] = 8'h5A;
        do_reset();
        tick(); tick(); tick();
        checks++;
        if (dm_out_dbus !== 8'h33 || im_abus !== 5'd2) begin
            errors++;
            $display("FAIL mov_first got acc=%h pc=%0d expected acc=33 pc=2", dm_out_dbus, im_abus);
        end
        tick(); tick();
        reset = 1'b1;
        #1;
        checks++;
        if ({rd_mem, wr_mem, im_abus, dm_abus, dm_out_dbus} !== 20'h0) begin
            errors++;
            $display("FAIL reset_in_imm_outputs got rd=%b wr=%b im=%0d dm=%0d out=%h expected all 0",
                     rd_mem, wr_mem, im_abus, dm_abus, dm_out_dbus);
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (im_abus !== 5'd0 || dm_out_dbus !== 8'h00) begin
            errors++;
            $display("FAIL reset_in_imm_state got pc=%0d acc=%h expected pc=0 acc=00", im_abus, dm_out_dbus);
        end
        tick();
        checks++;
        if (im_abus !== 5'd1) begin
            errors++;
            $display("FAIL reset_then_fetch got pc=%0d expected 1", im_abus);
        end
        tick(); tick();
        checks++;
        if (dm_out_dbus !== 8'h33 || im_abus !== 5'd2) begin
            errors++;
            $display("FAIL reset_then_mov got acc=%h pc=%0d expected acc=33 pc=2", dm_out_dbus, im_abus);
        end
    endtask

    task automatic test_axb_program;
        bit ok;
        logic [7:0] prog [27];
        logic stray;
        prog = '{8'h03, 8'h07, 8'h80, 8'h03, 8'h04, 8'h81, 8'h03, 8'h06, 8'h82,
                 8'h03, 8'h00, 8'h83, 8'h03, 8'h01, 8'h84,
                 8'h23, 8'h40, 8'h83, 8'h21, 8'h64, 8'h81, 8'hD7, 8'hAF,
                 8'h23, 8'h42, 8'h83, 8'h1F};
        clear_mem();
        for (int i = 0; i < 27; i++) imem[i] = prog[i];
        exp_wr(0, 8'd7); exp_wr(1, 8'd4); exp_wr(2, 8'd6); exp_wr(3, 8'd0); exp_wr(4, 8'd1);
        exp_wr(3, 8'd7);  exp_wr(1, 8'd3);
        exp_wr(3, 8'd14); exp_wr(1, 8'd2);
        exp_wr(3, 8'd21); exp_wr(1, 8'd1);
        exp_wr(3, 8'd28); exp_wr(1, 8'd0);
        exp_wr(3, 8'h22);
        sb_en = 1'b1;
        do_reset();
        wait_halt(600, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL axb_halt no halt within budget, pc=%0d", im_abus);
        end
        checks++;
        if (im_abus !== 5'd27) begin
            errors++;
            $display("FAIL axb_pc got %0d expected 27", im_abus);
        end
        checks++;
        if (dmem[3] !== 8'h22 || dmem[1] !== 8'h00) begin
            errors++;
            $display("FAIL axb_mem got mem3=%h mem1=%h expected mem3=22 mem1=00", dmem[3], dmem[1]);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL axb_writes %0d expected writes missing", exp_q.size());
        end
        stray = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            stray = stray | rd_mem | wr_mem;
        end
        checks++;
        if (stray !== 1'b0 || im_abus !== 5'd27) begin
            errors++;
            $display("FAIL halt_quiet got strobe=%b pc=%0d expected strobe=0 pc=27", stray, im_abus);
        end
        sb_en = 1'b0;
    endtask

    task automatic test_flags_branches;
        bit ok;
        logic [7:0] prog [18];
        prog = '{8'h03, 8'h01, 8'h81, 8'h21, 8'h61, 8'h82, 8'hC9, 8'h86, 8'h1F,
                 8'h61, 8'hED, 8'h84, 8'h1F, 8'h83, 8'hD1, 8'h85, 8'h1F, 8'h1F};
        clear_mem();
        for (int i = 0; i < 18; i++) imem[i] = prog[i];
        exp_wr(1, 8'h01); exp_wr(2, 8'h00); exp_wr(3, 8'hFF); exp_wr(5, 8'hFF);
        sb_en = 1'b1;
        do_reset();
        wait_halt(300, ok);
        checks++;
        if (!ok || im_abus !== 5'd17) begin
            errors++;
            $display("FAIL flags_halt got halted=%b pc=%0d expected halted=1 pc=17", ok, im_abus);
        end
        checks++;
        if (dm_out_dbus !== 8'hFF) begin
            errors++;
            $display("FAIL flags_acc got %h expected FF", dm_out_dbus);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL flags_writes %0d expected writes missing", exp_q.size());
        end
        sb_en = 1'b0;
    endtask

    task automatic test_stack;
        bit ok;
`ifdef SMPL_STACK_EN
        logic [7:0] prog [17];
        prog = '{8'h03, 8'h77, 8'h01, 8'h03, 8'h88, 8'h01, 8'h03, 8'h99, 8'h01,
                 8'h00, 8'h02, 8'h83, 8'h02, 8'h84, 8'h02, 8'h85, 8'h1F};
        clear_mem();
        for (int i = 0; i < 17; i++) imem[i] = prog[i];
        exp_wr(3, 8'h99); exp_wr(4, 8'h88); exp_wr(5, 8'h77);
`else
        logic [7:0] prog [8];
        prog = '{8'h03, 8'h42, 8'h01, 8'h03, 8'h13, 8'h02, 8'h83, 8'h1F};
        clear_mem();
        for (int i = 0; i < 8; i++) imem[i] = prog[i];
        exp_wr(3, 8'h13);
`endif
        sb_en = 1'b1;
        do_reset();
        wait_halt(300, ok);
        checks++;
`ifdef SMPL_STACK_EN
        if (!ok || im_abus !== 5'd17 || dmem[5] !== 8'h77) begin
            errors++;
            $display("FAIL stack_lifo got halted=%b pc=%0d mem5=%h expected halted=1 pc=17 mem5=77",
                     ok, im_abus, dmem[5]);
        end
`else
        if (!ok || im_abus !== 5'd8 || dmem[3] !== 8'h13) begin
            errors++;
            $display("FAIL stack_nop got halted=%b pc=%0d mem3=%h expected halted=1 pc=8 mem3=13",
                     ok, im_abus, dmem[3]);
        end
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stack_writes %0d expected writes missing", exp_q.size());
        end
        sb_en = 1'b0;
    endtask

`ifdef SMPL_STACK_EN
    task automatic test_stack_bounds;
        int n;
        clear_mem();
        imem[0] = 8'h03; imem[1] = 8'h01; imem[2] = 8'h80; imem[3] = 8'h01;
        for (int k = 0; k < 8; k++) begin
            imem[4 + 2 * k] = 8'h40;
            imem[5 + 2 * k] = 8'h01;
        end
        imem[20] = 8'h02; imem[21] = 8'h83; imem[22] = 8'hB4;
        exp_wr(0, 8'd1);
        for (int v = 8; v >= 1; v--) exp_wr(3, 8'(v));
        exp_wr(3, 8'd1);
        exp_wr(3, 8'd1);
        sb_en = 1'b1;
        do_reset();
        n = 0;
        while (exp_q.size() != 0 && n < 800) begin
            tick();
            n++;
        end
        sb_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stack_bounds_writes %0d expected writes missing", exp_q.size());
        end
        checks++;
        if (dm_out_dbus !== 8'h01) begin
            errors++;
            $display("FAIL stack_empty_pop got acc=%h expected 01", dm_out_dbus);
        end
    endtask
`endif

    task automatic test_wrap;
        clear_mem();
        imem[0]  = 8'hBF;
        imem[31] = 8'h00;
        do_reset();
        tick();
        tick();
        checks++;
        if (im_abus !== 5'd31) begin
            errors++;
            $display("FAIL wrap_jmp got pc=%0d expected 31", im_abus);
        end
        tick();
        checks++;
        if (im_abus !== 5'd0) begin
            errors++;
            $display("FAIL wrap_pc got pc=%0d expected 0", im_abus);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_imm();
        test_axb_program();
        test_flags_branches();
        test_stack();
`ifdef SMPL_STACK_EN
        test_stack_bounds();
`endif
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
